// File: rtl/mcdt_fmt_pkg.sv
// Shared types and header layout for the mcdt packet formatter.
package mcdt_fmt_pkg;

  typedef enum logic [2:0] {IDLE, REQ, HEAD, DATA, TAIL} fmt_state_e;

  localparam int          CHNL_NUM  = 3;
  localparam logic [7:0]  HDR_MAGIC = 8'hA5;

  // Header word: magic[31:24] | chnl[23:22] | pkt_len[21:16] | seq[15:0]
  localparam int HDR_W         = 32;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_MAGIC_W   = 8;
  localparam int HDR_CHNL_LSB  = 22;
  localparam int HDR_CHNL_W    = 2;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_LEN_W     = 6;
  localparam int HDR_SEQ_LSB   = 0;
  localparam int HDR_SEQ_W     = 16;

  function automatic logic [HDR_W-1:0] build_header(
    input logic [HDR_CHNL_W-1:0] chnl,
    input logic [HDR_LEN_W-1:0]  len,
    input logic [HDR_SEQ_W-1:0]  seq
  );
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = HDR_MAGIC;
    hdr[HDR_CHNL_LSB  +: HDR_CHNL_W]  = chnl;
    hdr[HDR_LEN_LSB   +: HDR_LEN_W]   = len;
    hdr[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/mcdt_pkt_formatter_fifo.sv
// Per-channel first-word-fall-through FIFO; rd_data always presents the oldest word.
module fmt_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes the write when a read frees a slot on the same edge.
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mcdt_pkt_formatter.sv
// Buffers the interleaved mcdt stream per channel and emits framed packets:
// header, PKT_LEN data words, XOR parity word.
module mcdt_pkt_formatter
  import mcdt_fmt_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] mcdt_data_i,
  input  logic              mcdt_val_i,
  input  logic [1:0]        mcdt_id_i,
  output logic              fmt_req_o,
  input  logic              fmt_grant_i,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              fmt_val_o,
  output logic              fmt_sop_o,
  output logic              fmt_eop_o,
  output logic [1:0]        fmt_chnl_o,
  output logic [2:0]        ovf_o,
  output logic              id_err_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(PKT_LEN + 1);

  fmt_state_e          state, state_nxt;
  logic [1:0]          chnl, last, pick, cand;
  logic                found;
  logic [BW-1:0]       beat;
  logic [15:0]         seq [CHNL_NUM];
  logic [DATA_W-1:0]   parity;
  logic [CHNL_NUM-1:0] wr_en, rd_en, full, empty, elig;
  logic [CW-1:0]       count   [CHNL_NUM];
  logic [DATA_W-1:0]   rd_data [CHNL_NUM];

  for (genvar i = 0; i < CHNL_NUM; i++) begin : g_ch
    assign wr_en[i] = mcdt_val_i && (mcdt_id_i == 2'(i));
    assign rd_en[i] = (state == DATA) && (chnl == 2'(i)) && !empty[i];
    assign elig[i]  = (count[i] >= CW'(PKT_LEN));

    fmt_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en[i]),
      .wr_data (mcdt_data_i),
      .rd_en   (rd_en[i]),
      .rd_data (rd_data[i]),
      .count   (count[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  // Round-robin: search starts at the channel after the last one served.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= CHNL_NUM; k++) begin
      cand = 2'((int'(last) + k) % CHNL_NUM);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fmt_req_o  = 1'b0;
    fmt_val_o  = 1'b0;
    fmt_sop_o  = 1'b0;
    fmt_eop_o  = 1'b0;
    fmt_data_o = '0;
    case (state)
      IDLE: if (found) state_nxt = REQ;
      REQ: begin
        fmt_req_o = 1'b1;
        if (fmt_grant_i) state_nxt = HEAD;
      end
      HEAD: begin
        fmt_val_o  = 1'b1;
        fmt_sop_o  = 1'b1;
        fmt_data_o = build_header(chnl, 6'(PKT_LEN), seq[chnl]);
        state_nxt  = DATA;
      end
      DATA: begin
        fmt_val_o  = 1'b1;
        fmt_data_o = rd_data[chnl];
        if (beat == BW'(PKT_LEN - 1)) state_nxt = TAIL;
      end
      TAIL: begin
        fmt_val_o  = 1'b1;
        fmt_eop_o  = 1'b1;
        fmt_data_o = parity;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      chnl     <= '0;
      last     <= 2'd2;
      beat     <= '0;
      ovf_o    <= '0;
      id_err_o <= 1'b0;
      for (int i = 0; i < CHNL_NUM; i++) seq[i] <= '0;
    end else begin
      if (state == IDLE && found) chnl <= pick;
      if (state == HEAD)      beat <= '0;
      else if (state == DATA) beat <= beat + BW'(1);
      if (state == TAIL) begin
        seq[chnl] <= seq[chnl] + 16'd1;
        last      <= chnl;
      end
      // A dropped word is a write to a full FIFO that no read is freeing.
      ovf_o <= ovf_o | (wr_en & full & ~rd_en);
      if (mcdt_val_i && mcdt_id_i == 2'd3) id_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == HEAD)      parity <= '0;
    else if (state == DATA) parity <= parity ^ rd_data[chnl];
  end

  assign fmt_chnl_o = chnl;

endmodule

// File: tb/tb_mcdt_pkt_formatter.sv
// Randomised and directed bench for mcdt_pkt_formatter against a packet-level queue model.
module tb_mcdt_pkt_formatter;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int PKT_LEN    = 4;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] mcdt_data_i = '0;
  logic              mcdt_val_i  = 1'b0;
  logic [1:0]        mcdt_id_i   = '0;
  logic              fmt_grant_i = 1'b0;
  logic              fmt_req_o, fmt_val_o, fmt_sop_o, fmt_eop_o, id_err_o;
  logic [DATA_W-1:0] fmt_data_o;
  logic [1:0]        fmt_chnl_o;
  logic [2:0]        ovf_o;

  always #5 clk = ~clk;

  mcdt_pkt_formatter #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mcdt_data_i (mcdt_data_i),
    .mcdt_val_i  (mcdt_val_i),
    .mcdt_id_i   (mcdt_id_i),
    .fmt_req_o   (fmt_req_o),
    .fmt_grant_i (fmt_grant_i),
    .fmt_data_o  (fmt_data_o),
    .fmt_val_o   (fmt_val_o),
    .fmt_sop_o   (fmt_sop_o),
    .fmt_eop_o   (fmt_eop_o),
    .fmt_chnl_o  (fmt_chnl_o),
    .ovf_o       (ovf_o),
    .id_err_o    (id_err_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue per channel; a packet is a precomputed word list replayed word by word.
  logic [31:0] mq [3][$];
  logic [31:0] m_pkt [PKT_LEN+2];
  logic [15:0] m_seq [3] = '{16'd0, 16'd0, 16'd0};
  int          m_chosen = -1;
  int          m_pos    = 0;
  int          m_last   = 2;
  bit          m_emit   = 1'b0;
  logic [1:0]  m_chnl   = '0;
  logic [2:0]  m_ovf    = '0;
  bit          m_iderr  = 1'b0;

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int c = 0; c < 3; c++) begin
        mq[c].delete();
        m_seq[c] = '0;
      end
      m_chosen = -1; m_emit = 1'b0; m_pos = 0; m_last = 2;
      m_chnl = '0; m_ovf = '0; m_iderr = 1'b0;
    end else begin
      if (m_emit) begin
        if (m_pos >= 1 && m_pos <= PKT_LEN) void'(mq[m_chosen].pop_front());
        if (m_pos == PKT_LEN + 1) begin
          m_seq[m_chosen] = m_seq[m_chosen] + 16'd1;
          m_last   = m_chosen;
          m_emit   = 1'b0;
          m_chosen = -1;
        end else begin
          m_pos++;
        end
      end else if (m_chosen >= 0) begin
        if (fmt_grant_i) begin
          logic [31:0] par;
          par = '0;
          m_pkt[0] = {8'hA5, 2'(m_chosen), 6'(PKT_LEN), m_seq[m_chosen]};
          for (int i = 0; i < PKT_LEN; i++) begin
            m_pkt[i+1] = mq[m_chosen][i];
            par = par ^ mq[m_chosen][i];
          end
          m_pkt[PKT_LEN+1] = par;
          m_emit = 1'b1;
          m_pos  = 0;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (m_chosen < 0 && mq[c].size() >= PKT_LEN) m_chosen = c;
        end
        if (m_chosen >= 0) m_chnl = 2'(m_chosen);
      end
      if (mcdt_val_i) begin
        if (mcdt_id_i == 2'd3) m_iderr = 1'b1;
        else if (mq[mcdt_id_i].size() < FIFO_DEPTH) mq[mcdt_id_i].push_back(mcdt_data_i);
        else m_ovf[mcdt_id_i] = 1'b1;
      end
    end
  end

  logic [31:0] obs [$];

  always @(negedge clk) begin
    logic [31:0] e_data;
    e_data = m_emit ? m_pkt[m_pos] : 32'h0;
    chk("req",    32'(fmt_req_o),  32'(m_chosen >= 0 && !m_emit));
    chk("val",    32'(fmt_val_o),  32'(m_emit));
    chk("sop",    32'(fmt_sop_o),  32'(m_emit && m_pos == 0));
    chk("eop",    32'(fmt_eop_o),  32'(m_emit && m_pos == PKT_LEN + 1));
    chk("data",   fmt_data_o,      e_data);
    chk("chnl",   32'(fmt_chnl_o), 32'(m_chnl));
    chk("ovf",    32'(ovf_o),      32'(m_ovf));
    chk("id_err", 32'(id_err_o),   32'(m_iderr));
    if (fmt_val_o) obs.push_back(fmt_data_o);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic [1:0] ch, input logic [31:0] d);
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = ch;
    mcdt_data_i = d;
    tick();
    mcdt_val_i  = 1'b0;
    mcdt_data_i = '0;
  endtask

  int s;
  bit seen;

  initial begin
    #1 rstn = 1'b1;
    idle(3);
    chk("rst_req",  32'(fmt_req_o), 32'h0);
    chk("rst_val",  32'(fmt_val_o), 32'h0);
    chk("rst_data", fmt_data_o,     32'h0);
    chk("rst_ovf",  32'(ovf_o),     32'h0);
    chk("rst_ierr", 32'(id_err_o),  32'h0);
    rstn = 1'b0;
    idle(2);

    // Single ch0 packet, grant tied high
    fmt_grant_i = 1'b1;
    s = obs.size();
    for (int i = 0; i < 4; i++) put(2'd0, 32'hC000_0000 + i);
    idle(15);
    chk("t1_len", obs.size() - s, 6);
    if (obs.size() - s == 6) begin
      chk("t1_hdr", obs[s], 32'hA504_0000);
      for (int i = 0; i < 4; i++) chk("t1_dat", obs[s+1+i], 32'hC000_0000 + i);
      chk("t1_par", obs[s+5], 32'h0000_0000);
    end

    // ch1/ch2 interleaved, then a second ch1 burst
    s = obs.size();
    for (int i = 0; i < 4; i++) begin
      put(2'd1, 32'h1100_0001 + 3 * i);
      put(2'd2, 32'h2200_0000 + i);
    end
    for (int i = 0; i < 4; i++) put(2'd1, 32'h1100_0010 + i);
    idle(40);
    chk("t2_len", obs.size() - s, 18);
    if (obs.size() - s == 18) begin
      chk("t2_hdr_a", obs[s],    32'hA544_0000);
      chk("t2_dat_a", obs[s+1],  32'h1100_0001);
      chk("t2_par_a", obs[s+5],  32'h0000_0008);
      chk("t2_hdr_b", obs[s+6],  32'hA584_0000);
      chk("t2_hdr_c", obs[s+12], 32'hA544_0001);
    end

    // Grant withheld for 20 cycles
    fmt_grant_i = 1'b0;
    s = obs.size();
    for (int i = 0; i < 4; i++) put(2'd0, 32'h0C00_0000 + i);
    idle(20);
    chk("t3_req_hold", 32'(fmt_req_o), 32'h1);
    chk("t3_no_val",   32'(fmt_val_o), 32'h0);
    chk("t3_no_words", obs.size() - s, 0);
    fmt_grant_i = 1'b1;
    tick();
    chk("t3_sop",  32'(fmt_sop_o), 32'h1);
    chk("t3_hdr",  fmt_data_o,     32'hA504_0001);
    chk("t3_req0", 32'(fmt_req_o), 32'h0);
    idle(10);

    // Overflow: 33 words into ch2 with no grant
    fmt_grant_i = 1'b0;
    for (int i = 0; i < 33; i++) put(2'd2, 32'h2000_0000 + i);
    idle(2);
    chk("t4_ovf", 32'(ovf_o), 32'h4);
    s = obs.size();
    fmt_grant_i = 1'b1;
    idle(90);
    chk("t4_len", obs.size() - s, 48);
    if (obs.size() - s == 48) begin
      for (int p = 0; p < 8; p++) begin
        chk("t4_hdr", obs[s+p*6], 32'hA584_0001 + p);
        for (int w = 0; w < 4; w++) chk("t4_dat", obs[s+p*6+1+w], 32'h2000_0000 + p * 4 + w);
      end
    end
    chk("t4_ovf_sticky", 32'(ovf_o), 32'h4);

    // Illegal id
    s = obs.size();
    put(2'd3, 32'hDEAD_BEEF);
    idle(3);
    chk("t5_ierr",  32'(id_err_o), 32'h1);
    chk("t5_nopkt", obs.size() - s, 0);
    for (int i = 0; i < 4; i++) put(2'd0, 32'h0A00_0000 + i);
    idle(12);
    chk("t5_len", obs.size() - s, 6);
    if (obs.size() - s == 6) begin
      chk("t5_hdr", obs[s],   32'hA504_0002);
      chk("t5_dat", obs[s+1], 32'h0A00_0000);
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      fmt_grant_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        mcdt_val_i  = 1'b1;
        mcdt_id_i   = ($urandom_range(0, 40) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        mcdt_data_i = $urandom;
      end else begin
        mcdt_val_i  = 1'b0;
        mcdt_data_i = '0;
      end
      tick();
    end
    mcdt_val_i  = 1'b0;
    mcdt_data_i = '0;
    fmt_grant_i = 1'b1;
    idle(150);

    // Reset in the middle of a ch0 packet
    rstn = 1'b1;
    idle(2);
    rstn = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) put(2'd0, 32'h7000_0000 + i);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fmt_val_o && !fmt_sop_o) seen = 1'b1;
    end
    chk("t6_in_data", 32'(seen), 32'h1);
    rstn = 1'b1;
    #1;
    chk("t6_val",  32'(fmt_val_o),  32'h0);
    chk("t6_data", fmt_data_o,      32'h0);
    chk("t6_eop",  32'(fmt_eop_o),  32'h0);
    chk("t6_chnl", 32'(fmt_chnl_o), 32'h0);
    idle(2);
    rstn = 1'b0;
    idle(1);
    s = obs.size();
    for (int i = 0; i < 4; i++) put(2'd0, 32'h7100_0000 + i);
    idle(12);
    chk("t6_len", obs.size() - s, 6);
    if (obs.size() - s == 6) begin
      chk("t6_hdr", obs[s],   32'hA504_0000);
      chk("t6_par", obs[s+5], 32'h0000_0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
